// File: rtl/rs232_pkg.sv
// Shared constants and state encoding for the RS232 link.
// The transmitter and receiver both use these, so their bit timing always matches.
package rs232_pkg;

    // One bit lasts BAUD_CNT_MAX+1 clock cycles: 50 MHz / 9600 baud.
    localparam logic [12:0] BAUD_CNT_MAX = 13'd5207;
    localparam logic [3:0]  DATA_BITS    = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/rs232_baud_cnt.sv
// Bit-period counter. It runs while enable is high and is held at zero otherwise.
// bit_end marks the last cycle of each bit period.
module rs232_baud_cnt #(
    parameter logic [12:0] BAUD_CNT_MAX = 13'd5207
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic enable,
    output logic bit_end
);

    logic [12:0] baud_cnt;

    assign bit_end = enable && (baud_cnt == BAUD_CNT_MAX);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            baud_cnt <= '0;
        end else if (!enable || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 13'd1;
        end
    end

endmodule

// File: rtl/rs232_tx.sv
// RS232 8N1 transmitter. A one-byte holding register feeds a shift register,
// so a byte written during a frame follows it with no idle gap.
module rs232_tx
    import rs232_pkg::*;
#(
    parameter logic [12:0] BAUD_CNT_MAX = rs232_pkg::BAUD_CNT_MAX
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx,
    output logic       flag_txe,
    output logic       tx_busy,
    output logic       tx_done
);

    tx_state_t  state,     state_nxt;
    logic [7:0] hold_reg,  hold_reg_nxt;
    logic       hold_full, hold_full_nxt;
    logic [7:0] shift_reg, shift_reg_nxt;
    logic [3:0] bit_cnt,   bit_cnt_nxt;
    logic       tx_nxt;
    logic       bit_end;
    logic       wr_accept;
    logic       load;

    rs232_baud_cnt #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX)
    ) u_baud_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    assign flag_txe  = ~hold_full;
    assign tx_busy   = (state != IDLE);
    assign wr_accept = tx_wr && flag_txe;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        hold_reg_nxt  = hold_reg;
        hold_full_nxt = hold_full;
        shift_reg_nxt = shift_reg;
        bit_cnt_nxt   = bit_cnt;
        tx_nxt        = tx;
        tx_done       = 1'b0;
        load          = 1'b0;

        unique case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                load   = hold_full;
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_reg_nxt = {1'b0, shift_reg[7:1]};
                    bit_cnt_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == DATA_BITS - 4'd1) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        tx_nxt = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done   = 1'b1;
                    state_nxt = IDLE;
                    load      = hold_full;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A pending byte moves into the shifter and its start bit begins next cycle.
        if (load) begin
            shift_reg_nxt = hold_reg;
            hold_full_nxt = 1'b0;
            state_nxt     = START;
            tx_nxt        = 1'b0;
        end

        // wr_accept needs hold_full low and load needs it high, so they never coincide.
        if (wr_accept) begin
            hold_reg_nxt  = tx_data;
            hold_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: the data registers are reset too, so a frame aborted by reset leaves nothing behind.
            state     <= IDLE;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nxt;
            hold_reg  <= hold_reg_nxt;
            hold_full <= hold_full_nxt;
            shift_reg <= shift_reg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx        <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: a fast instance (4 cycles/bit) checked against a line-level
// receiver model, plus a full-rate instance for frame length and decode.
module tb_rs232_tx;

    localparam int BIT_CYC      = 4;
    localparam int FULL_BIT_CYC = 5208;

    logic       sys_clk  = 1'b0;
    logic       sys_rst  = 1'b1;
    logic [7:0] tx_data  = '0;
    logic       tx_wr    = 1'b0;
    logic       tx, flag_txe, tx_busy, tx_done;

    logic [7:0] f_tx_data = '0;
    logic       f_tx_wr   = 1'b0;
    logic       f_tx, f_flag_txe, f_tx_busy, f_tx_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    rs232_tx #(.BAUD_CNT_MAX(13'd3)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx       (tx),
        .flag_txe (flag_txe),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    rs232_tx dut_full (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tx_data  (f_tx_data),
        .tx_wr    (f_tx_wr),
        .tx       (f_tx),
        .flag_txe (f_flag_txe),
        .tx_busy  (f_tx_busy),
        .tx_done  (f_tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Cycle number of every tx_done pulse of the fast instance.
    int done_q[$];
    always @(negedge sys_clk) begin
        if (tx_done === 1'b1) done_q.push_back(cyc);
    end

    // Line-level receiver model: find the falling start edge, sample each bit mid-period.
    logic [7:0] rx_q[$];
    int         frame_err = 0;
    bit         rx_active = 1'b0;
    int         rx_pos    = 0;
    int         rx_bit    = 0;
    logic       rx_prev   = 1'b1;
    logic [7:0] rx_sh     = '0;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (rx_prev === 1'b1 && tx === 1'b0) begin
                rx_active = 1'b1;
                rx_pos    = 0;
            end
        end else begin
            rx_pos++;
            if (rx_pos % BIT_CYC == BIT_CYC / 2) begin
                rx_bit = rx_pos / BIT_CYC;
                if (rx_bit == 0) begin
                    if (tx !== 1'b0) frame_err++;
                end else if (rx_bit <= 8) begin
                    rx_sh[rx_bit-1] = tx;
                end else begin
                    if (tx !== 1'b1) frame_err++;
                    rx_q.push_back(rx_sh);
                    rx_active = 1'b0;
                end
            end
        end
        rx_prev = tx;
    end

    // Expected line level in cycle k (1-based) of a frame carrying b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int bit_i;
        bit_i = (k - 1) / BIT_CYC;
        if (bit_i == 0) return 1'b0;
        if (bit_i <= 8) return b[bit_i-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        tick();
        tx_wr   = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (flag_txe !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (flag_txe !== 1'b1) begin
            n_err++;
            $display("FAIL wait_ready: flag_txe=%b after %0d cycles, required 1", flag_txe, n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((tx_busy !== 1'b0 || flag_txe !== 1'b1) && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (tx_busy !== 1'b0 || flag_txe !== 1'b1) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b flag_txe=%b after %0d cycles, required 0/1",
                     tx_busy, flag_txe, n);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_vec++;
        if ({tx, flag_txe, tx_busy, tx_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_state: {tx,txe,busy,done}=%b, required 1100",
                     {tx, flag_txe, tx_busy, tx_done});
        end
        n_vec++;
        if ({f_tx, f_flag_txe, f_tx_busy, f_tx_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_state_full: {tx,txe,busy,done}=%b, required 1100",
                     {f_tx, f_flag_txe, f_tx_busy, f_tx_done});
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_vec++;
            if ({tx, flag_txe, tx_busy, tx_done} !== 4'b1100) begin
                n_err++;
                $display("FAIL idle_cycle %0d: {tx,txe,busy,done}=%b, required 1100",
                         i, {tx, flag_txe, tx_busy, tx_done});
            end
        end
        n_vec++;
        if (done_q.size() != 0) begin
            n_err++;
            $display("FAIL idle_done: %0d tx_done pulses, required 0", done_q.size());
        end
    endtask

    // Cycle-exact waveform of one frame, starting at the write edge.
    task automatic test_single(input logic [7:0] b);
        int base_done = done_q.size();
        int base_rx   = rx_q.size();
        int e;
        logic [3:0] exp_v;
        write_byte(b);
        e = cyc;
        n_vec++;
        if ({tx, flag_txe, tx_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL single_write_edge: {tx,txe,busy}=%b, required 100", {tx, flag_txe, tx_busy});
        end
        for (int k = 1; k <= 41; k++) begin
            tick();
            exp_v = (k <= 40) ? {exp_line(b, k), 1'b1, 1'b1, (k == 40)} : 4'b1100;
            n_vec++;
            if ({tx, flag_txe, tx_busy, tx_done} !== exp_v) begin
                n_err++;
                $display("FAIL single_wave byte %h cycle %0d: {tx,txe,busy,done}=%b, required %b",
                         b, k, {tx, flag_txe, tx_busy, tx_done}, exp_v);
            end
        end
        n_vec++;
        if (done_q.size() != base_done + 1 || (done_q.size() > base_done && done_q[base_done] != e + 40)) begin
            n_err++;
            $display("FAIL single_done: %0d pulses (first at offset %0d), required 1 at offset 40",
                     done_q.size() - base_done,
                     (done_q.size() > base_done) ? done_q[base_done] - e : -1);
        end
        n_vec++;
        if (rx_q.size() != base_rx + 1 || (rx_q.size() > base_rx && rx_q[base_rx] !== b)) begin
            n_err++;
            $display("FAIL single_decode: %0d bytes, first %h, required 1 byte %h",
                     rx_q.size() - base_rx, (rx_q.size() > base_rx) ? rx_q[base_rx] : 8'hxx, b);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
        int base_done = done_q.size();
        int base_rx   = rx_q.size();
        int e;
        write_byte(a);
        e = cyc;
        wait_ready(10);
        write_byte(b);
        wait_idle(200);
        n_vec++;
        if (rx_q.size() != base_rx + 2 ||
            (rx_q.size() == base_rx + 2 && (rx_q[base_rx] !== a || rx_q[base_rx+1] !== b))) begin
            n_err++;
            $display("FAIL b2b_decode: %0d bytes received, required %h then %h", rx_q.size() - base_rx, a, b);
        end
        n_vec++;
        if (done_q.size() != base_done + 2) begin
            n_err++;
            $display("FAIL b2b_done_count: %0d pulses, required 2", done_q.size() - base_done);
        end else begin
            n_vec++;
            if (done_q[base_done] != e + 40 || done_q[base_done+1] != e + 80) begin
                n_err++;
                $display("FAIL b2b_gap: done at offsets %0d and %0d, required 40 and 80",
                         done_q[base_done] - e, done_q[base_done+1] - e);
            end
        end
    endtask

    task automatic test_overrun();
        int base_done = done_q.size();
        int base_rx   = rx_q.size();
        write_byte(8'h0F);
        wait_ready(10);
        repeat (10) tick();
        write_byte(8'h81);
        repeat (3) tick();
        n_vec++;
        if (flag_txe !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_flag: flag_txe=%b with byte pending, required 0", flag_txe);
        end
        write_byte(8'hFF);
        wait_idle(300);
        n_vec++;
        if (rx_q.size() != base_rx + 2 ||
            (rx_q.size() == base_rx + 2 && (rx_q[base_rx] !== 8'h0F || rx_q[base_rx+1] !== 8'h81))) begin
            n_err++;
            $display("FAIL overrun_decode: %0d bytes received, required 0f then 81", rx_q.size() - base_rx);
        end
        n_vec++;
        if (done_q.size() != base_done + 2) begin
            n_err++;
            $display("FAIL overrun_done: %0d pulses, required 2", done_q.size() - base_done);
        end
    endtask

    task automatic test_reset_mid();
        int base_done = done_q.size();
        int base_rx   = rx_q.size();
        int e;
        write_byte(8'hC6);
        e = cyc;
        wait_ready(10);
        write_byte(8'($urandom));
        while (cyc < e + 22) tick();
        n_vec++;
        if (tx !== exp_line(8'hC6, 22)) begin
            n_err++;
            $display("FAIL midreset_bit4: tx=%b, required %b", tx, exp_line(8'hC6, 22));
        end
        sys_rst = 1'b1;
        tick();
        n_vec++;
        if ({tx, flag_txe, tx_busy, tx_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL midreset_edge: {tx,txe,busy,done}=%b, required 1100",
                     {tx, flag_txe, tx_busy, tx_done});
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_vec++;
            if ({tx, flag_txe, tx_busy} !== 3'b110) begin
                n_err++;
                $display("FAIL midreset_quiet %0d: {tx,txe,busy}=%b, required 110", i, {tx, flag_txe, tx_busy});
            end
        end
        n_vec++;
        if (done_q.size() != base_done || rx_q.size() != base_rx) begin
            n_err++;
            $display("FAIL midreset_abort: %0d pulses, %0d bytes, required 0 and 0",
                     done_q.size() - base_done, rx_q.size() - base_rx);
        end
        write_byte(8'h12);
        wait_idle(100);
        n_vec++;
        if (rx_q.size() != base_rx + 1 || (rx_q.size() > base_rx && rx_q[base_rx] !== 8'h12) ||
            done_q.size() != base_done + 1) begin
            n_err++;
            $display("FAIL midreset_recover: %0d bytes (first %h), %0d pulses, required 1 byte 12 and 1 pulse",
                     rx_q.size() - base_rx, (rx_q.size() > base_rx) ? rx_q[base_rx] : 8'hxx,
                     done_q.size() - base_done);
        end
    endtask

    task automatic test_random(input int n_bytes);
        logic [7:0] exp_q[$];
        int base_done = done_q.size();
        int base_rx   = rx_q.size();
        int base_ferr = frame_err;
        logic [7:0] b;
        for (int i = 0; i < n_bytes; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 60)) tick();
            wait_ready(200);
            write_byte(b);
            exp_q.push_back(b);
        end
        wait_idle(1000);
        n_vec++;
        if (rx_q.size() != base_rx + n_bytes) begin
            n_err++;
            $display("FAIL random_count: %0d bytes received, required %0d", rx_q.size() - base_rx, n_bytes);
        end else begin
            for (int i = 0; i < n_bytes; i++) begin
                n_vec++;
                if (rx_q[base_rx+i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL random_byte %0d: received %h, required %h", i, rx_q[base_rx+i], exp_q[i]);
                end
            end
        end
        n_vec++;
        if (done_q.size() != base_done + n_bytes || frame_err != base_ferr) begin
            n_err++;
            $display("FAIL random_frames: %0d pulses, %0d framing errors, required %0d and 0",
                     done_q.size() - base_done, frame_err - base_ferr, n_bytes);
        end
    endtask

    task automatic test_full_baud();
        int e;
        int f    = -1;
        int d    = -1;
        int n    = 0;
        logic [9:0] frame = 'x;
        f_tx_data = 8'h41;
        f_tx_wr   = 1'b1;
        tick();
        f_tx_wr   = 1'b0;
        e = cyc;
        while (f_tx !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        f = cyc;
        n_vec++;
        if (f != e + 1) begin
            n_err++;
            $display("FAIL full_latency: tx fell %0d cycles after write, required 1", f - e);
        end
        for (int k = 0; k < 10 * FULL_BIT_CYC + 10; k++) begin
            if (k < 10 * FULL_BIT_CYC && k % FULL_BIT_CYC == FULL_BIT_CYC / 2)
                frame[k / FULL_BIT_CYC] = f_tx;
            if (f_tx_done === 1'b1 && d < 0) d = cyc;
            tick();
        end
        n_vec++;
        if (d - f + 1 != 10 * FULL_BIT_CYC) begin
            n_err++;
            $display("FAIL full_length: frame lasted %0d cycles, required %0d", d - f + 1, 10 * FULL_BIT_CYC);
        end
        n_vec++;
        if (frame !== {1'b1, 8'h41, 1'b0}) begin
            n_err++;
            $display("FAIL full_decode: frame bits %b, required %b", frame, {1'b1, 8'h41, 1'b0});
        end
        n_vec++;
        if ({f_tx, f_flag_txe, f_tx_busy} !== 3'b110) begin
            n_err++;
            $display("FAIL full_idle: {tx,txe,busy}=%b, required 110", {f_tx, f_flag_txe, f_tx_busy});
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_back_to_back(8'hA3, 8'h3C);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_overrun();
        test_reset_mid();
        test_random(8);
        test_full_baud();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
